// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: latch enables/flushes, PC enable, halt drain.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned PERF_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              ex_MemtoReg,
    input  logic [REG_W-1:0]  ex_wsel,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              mem_dREN,
    input  logic              mem_dWEN,
    input  logic              mem_redirect,
    input  logic              mem_halt,
    output logic              pc_en,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_en,
    output logic              de_flush,
    output logic              em_en,
    output logic              em_flush,
    output logic              mw_en,
    output logic              mw_flush,
    output logic              halt,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDwait, StDrain, StHalted} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_q, halt_d;

    logic memreq, dstall, lu;

    assign memreq = mem_dREN | mem_dWEN;
    assign dstall = memreq & ~dhit;
    assign lu     = ex_MemtoReg & (ex_wsel != '0) &
                    ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StRun;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        unique case (state_q)
            StRun, StDwait: begin
                if (dstall) begin
                    state_d = StDwait;
                end else if (mem_halt) begin
                    state_d = StDrain;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = StRun;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StHalted;
                    halt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: state_d = StRun;
        endcase
    end

    // A flushed latch always has its enable low, so flush wins unambiguously.
    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        fd_flush = 1'b0;
        de_en    = 1'b0;
        de_flush = 1'b0;
        em_en    = 1'b0;
        em_flush = 1'b0;
        mw_en    = 1'b0;
        mw_flush = 1'b0;
        unique case (state_q)
            StRun, StDwait: begin
                if (dstall) begin
                    pc_en = 1'b0;
                end else if (mem_halt) begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    em_flush = 1'b1;
                    mw_en    = 1'b1;
                end else if (mem_redirect) begin
                    pc_en    = 1'b1;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    em_flush = 1'b1;
                    mw_en    = 1'b1;
                end else if (lu) begin
                    de_flush = 1'b1;
                    em_en    = 1'b1;
                    mw_en    = 1'b1;
                end else if (!ihit) begin
                    fd_flush = 1'b1;
                    de_en    = 1'b1;
                    em_en    = 1'b1;
                    mw_en    = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                    de_en = 1'b1;
                    em_en = 1'b1;
                    mw_en = 1'b1;
                end
            end
            StDrain: begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
                mw_en    = 1'b1;
            end
            StHalted: begin
                pc_en = 1'b0;
            end
            default: pc_en = 1'b0;
        endcase
        // Keep every latch quiet while reset is held.
        if (!nRST) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            fd_flush = 1'b0;
            de_en    = 1'b0;
            de_flush = 1'b0;
            em_en    = 1'b0;
            em_flush = 1'b0;
            mw_en    = 1'b0;
            mw_flush = 1'b0;
        end
    end

    assign halt = halt_q;

`ifdef PIPE_PERF_EN
    logic              run_like, stall_evt, flush_evt;
    logic [PERF_W-1:0] stall_q, flush_q;

    assign run_like  = (state_q == StRun) || (state_q == StDwait);
    assign stall_evt = run_like & (dstall | (~mem_halt & ~mem_redirect & lu));
    assign flush_evt = run_like & ~dstall & ~mem_halt & mem_redirect;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
            if (flush_evt && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; expected counters follow PIPE_PERF_EN.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 32;

    // Packed as {pc, fd_en, fd_fl, de_en, de_fl, em_en, em_fl, mw_en, mw_fl}.
    localparam logic [8:0] V_NONE  = 9'b0_00_00_00_00;
    localparam logic [8:0] V_ALL   = 9'b1_10_10_10_10;
    localparam logic [8:0] V_DRAIN = 9'b0_01_01_01_10;
    localparam logic [8:0] V_REDIR = 9'b1_01_01_01_10;
    localparam logic [8:0] V_LU    = 9'b0_00_01_10_10;
    localparam logic [8:0] V_IMISS = 9'b0_01_10_10_10;

`ifdef PIPE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             CLK, nRST;
    logic             ihit, dhit, ex_MemtoReg, id_uses_rt;
    logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
    logic             mem_dREN, mem_dWEN, mem_redirect, mem_halt;
    logic             pc_en, fd_en, fd_flush, de_en, de_flush;
    logic             em_en, em_flush, mw_en, mw_flush, halt;
    logic [PERF_W-1:0] stall_cycles, flush_count;
    logic [8:0]       ctl;

    int vectors     = 0;
    int miscompares = 0;
    int exp_stall   = 0;
    int exp_flush   = 0;

    pipeline_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(2), .PERF_W(PERF_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .ex_MemtoReg  (ex_MemtoReg),
        .ex_wsel      (ex_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .mem_dREN     (mem_dREN),
        .mem_dWEN     (mem_dWEN),
        .mem_redirect (mem_redirect),
        .mem_halt     (mem_halt),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .fd_flush     (fd_flush),
        .de_en        (de_en),
        .de_flush     (de_flush),
        .em_en        (em_en),
        .em_flush     (em_flush),
        .mw_en        (mw_en),
        .mw_flush     (mw_flush),
        .halt         (halt),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    assign ctl = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [8:0] exp);
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, "_stall"}, 32'(stall_cycles), PERF_ON ? 32'(exp_stall) : 32'd0);
        chk({tag, "_flush"}, 32'(flush_count), PERF_ON ? 32'(exp_flush) : 32'd0);
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; ex_MemtoReg = 1'b0; id_uses_rt = 1'b0;
        ex_wsel = '0; id_rs = '0; id_rt = '0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_redirect = 1'b0; mem_halt = 1'b0;
    endtask

    // Inputs change just after a falling edge; outputs are checked 2 time units later.
    task automatic next();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        next();
        #2;
        chk_ctl("reset_ctl", V_NONE);
        chk("reset_halt", 32'(halt), 32'd0);
        chk_perf("reset");
        next();
        nRST = 1'b1;

        // Plain flow.
        #2 chk_ctl("run_all_en", V_ALL);

        // Load-use on rs.
        next();
        ex_MemtoReg = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
        #2 chk_ctl("lu_rs", V_LU);
        exp_stall++;
        next();
        idle();
        #2 chk_ctl("lu_release", V_ALL);
        chk_perf("after_lu");

        // Load-use on rt, only when decode reads rt.
        next();
        ex_MemtoReg = 1'b1; ex_wsel = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #2 chk_ctl("lu_rt", V_LU);
        exp_stall++;
        next();
        id_uses_rt = 1'b0;
        #2 chk_ctl("lu_rt_unused", V_ALL);
        next();
        idle();
        ex_MemtoReg = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
        #2 chk_ctl("lu_r0", V_ALL);

        // dcache miss for three cycles, then zero-bubble release.
        next();
        idle();
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk_ctl("dstall", V_NONE);
            exp_stall++;
            next();
        end
        dhit = 1'b1;
        #2 chk_ctl("dhit_release", V_ALL);
        next();
        idle();
        #2 chk_ctl("after_dwait", V_ALL);
        chk_perf("after_dstall");

        // Redirect beats load-use and icache miss.
        next();
        mem_redirect = 1'b1; ihit = 1'b0;
        ex_MemtoReg = 1'b1; ex_wsel = 5'd9; id_rs = 5'd9;
        #2 chk_ctl("redir_prio", V_REDIR);
        exp_flush++;
        next();
        idle();
        #2 chk_perf("after_redir");

        // Redirect coincident with a dcache stall waits for dhit.
        next();
        mem_redirect = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
        #2 chk_ctl("redir_dstall0", V_NONE);
        exp_stall++;
        next();
        #2 chk_ctl("redir_dstall1", V_NONE);
        exp_stall++;
        next();
        dhit = 1'b1;
        #2 chk_ctl("redir_on_dhit", V_REDIR);
        exp_flush++;
        next();
        idle();
        #2 chk_ctl("redir_once", V_ALL);
        chk_perf("after_redir_dstall");

        // icache miss.
        next();
        ihit = 1'b0;
        #2 chk_ctl("imiss", V_IMISS);

        // Halt: accept, two drain cycles, then frozen.
        next();
        idle();
        mem_halt = 1'b1;
        #2 chk_ctl("halt_accept", V_DRAIN);
        chk("halt_accept_h", 32'(halt), 32'd0);
        next();
        mem_halt = 1'b0;
        #2 chk_ctl("drain1", V_DRAIN);
        chk("drain1_h", 32'(halt), 32'd0);
        next();
        #2 chk_ctl("drain2", V_DRAIN);
        chk("drain2_h", 32'(halt), 32'd0);
        next();
        ihit = 1'b0; mem_redirect = 1'b1; mem_dREN = 1'b1; dhit = 1'b1;
        #2 chk_ctl("halted0", V_NONE);
        chk("halted0_h", 32'(halt), 32'd1);
        next();
        ihit = 1'b1; mem_redirect = 1'b0; mem_dREN = 1'b0;
        #2 chk_ctl("halted1", V_NONE);
        chk("halted1_h", 32'(halt), 32'd1);
        chk_perf("halted");

        // Reset out of HALTED, re-enter DRAIN, then pulse reset mid-drain.
        next();
        nRST = 1'b0;
        idle();
        next();
        nRST = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        #2 chk_ctl("rerun", V_ALL);
        next();
        mem_halt = 1'b1;
        #2 chk_ctl("halt_accept2", V_DRAIN);
        next();
        mem_halt = 1'b0;
        #2 chk_ctl("drain_again", V_DRAIN);
        #1 nRST = 1'b0;
        #1 chk_ctl("rst_in_drain", V_NONE);
        chk("rst_in_drain_h", 32'(halt), 32'd0);
        chk_perf("rst_in_drain");
        next();
        nRST = 1'b1;
        #2 chk_ctl("resume", V_ALL);
        chk("resume_h", 32'(halt), 32'd0);
        next();
        #2 chk_ctl("resume2", V_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
